mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath: replaces single-cycle decode with a Moore FSM

---
 rtl/mips_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer (Moore FSM).
// Steps FETCH/DECODE/EXEC/MEM/WB, drives the datapath selects and strobes, stalls on
// mem_ready, and traps on illegal opcodes/functs and on memory wait timeouts.
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt / retire_cnt performance counters.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_ctr,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic [1:0] trap_cause
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        WB_I   = 4'd8,
        WB_MEM = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter only needs to reach MEM_TIMEOUT-1: the cycle that would reach the limit traps instead.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [1:0]        trap_q, trap_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        alu_r;
    logic              func_ok;
    logic              waiting;
    logic              timeout;

    // R-type funct decode into an ALU operation plus a legality flag
    always_comb begin
        func_ok = 1'b1;
        case (func)
            6'b100000: alu_r = 3'b010;
            6'b100010: alu_r = 3'b110;
            6'b100100: alu_r = 3'b000;
            6'b100101: alu_r = 3'b001;
            6'b101010: alu_r = 3'b111;
            default: begin
                alu_r   = 3'b010;
                func_ok = 1'b0;
            end
        endcase
    end

    // Next state, sticky trap cause and memory wait counter
    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        wait_d  = '0;
        waiting = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR)) && !mem_ready;
        timeout = waiting && (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_ADDI:      state_d = EXEC_I;
                    OP_LW, OP_SW: state_d = ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = TRAP;
                        trap_d  = CAUSE_ILLEGAL;
                    end
                endcase
            end
            EXEC_R: begin
                if (func_ok) begin
                    state_d = WB_R;
                end else begin
                    state_d = TRAP;
                    trap_d  = CAUSE_ILLEGAL;
                end
            end
            EXEC_I: state_d = WB_I;
            ADDR:   state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: if (mem_ready) state_d = WB_MEM;
            MEM_WR: if (mem_ready) state_d = FETCH;
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = FETCH;
        endcase
        if (timeout) begin
            state_d = TRAP;
            trap_d  = CAUSE_TIMEOUT;
        end else if (waiting && (MEM_TIMEOUT != 0)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            trap_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            wait_q  <= wait_d;
        end
    end

    // Moore output decode; everything held low while Reset is asserted
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALU_ctr  = 3'b000;
        PCSrc    = 2'b00;
        if (!Reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALU_ctr = 3'b010;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    ALU_ctr = 3'b010;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALU_ctr = alu_r;
                end
                EXEC_I, ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALU_ctr = 3'b010;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                WB_I:   RegWrite = 1'b1;
                WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALU_ctr = 3'b110;
                    PCSrc   = 2'b01;
                    PCWrite = Zero;
                end
                JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign trap_cause = trap_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q, retire_q;
    logic        retire_ev;

    // An instruction retires on the edge that returns to FETCH from a final state
    always_comb begin
        retire_ev = (state_d == FETCH) &&
                    ((state_q == WB_R) || (state_q == WB_I) || (state_q == WB_MEM) ||
                     (state_q == MEM_WR) || (state_q == BRANCH) || (state_q == JUMP));
    end

    // Free-running performance counters, frozen in TRAP
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (state_q != TRAP) cycle_q <= cycle_q + 32'd1;
            if (retire_ev) retire_q <= retire_q + 32'd1;
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table, hand-written
// trap/timeout sequences, and randomized instruction streams checked against a
// plan-based reference of the instruction sequencing rules.
module tb_mips_multicycle_ctrl;

    localparam int unsigned TO = 16;

    localparam logic [5:0] R_OP = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [5:0] op, func;
    logic       Zero, mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, trap_cause;
    logic [2:0] ALU_ctr;
    logic [3:0] state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retire_cnt;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .op(op), .func(func), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALU_ctr(ALU_ctr), .PCSrc(PCSrc), .state(state), .trap_cause(trap_cause)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] pcsrc;
        logic [3:0] st;
        logic [1:0] cause;
    } ov_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, fn;
        logic       z, mr;
        logic [3:0] st;
        logic [4:0] strb;   // {PCWrite, MemRead, MemWrite, IRWrite, RegWrite}
        logic [3:0] cm;     // care for {IorD, RegDst, MemtoReg, PCSrc}
        logic       iord, rdst, m2r;
        logic [1:0] pcsrc, cause;
    } row_t;

    typedef struct {
        int         st;
        logic       mr;
        logic [1:0] cause;
    } pe_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    row_t tbl[$];
    pe_t  plan[$];
    bit   trapped;

    function automatic ov_t dut_out();
        ov_t o;
        o.pcw = PCWrite; o.iord = IorD; o.mrd = MemRead; o.mwr = MemWrite; o.irw = IRWrite;
        o.rdst = RegDst; o.m2r = MemtoReg; o.rw = RegWrite; o.srca = ALUSrcA; o.srcb = ALUSrcB;
        o.alu = ALU_ctr; o.pcsrc = PCSrc; o.st = state; o.cause = trap_cause;
        return o;
    endfunction

    task automatic check(input string name, input ov_t exp, input ov_t care);
        ov_t act;
        act = dut_out();
        n_checks++;
        if (((act ^ exp) & care) !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (care %h) t=%0t", name, act, exp, care, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic m);
        @(negedge Clock);
        Reset = r; op = o; func = f; Zero = z; mem_ready = m;
        #1;
    endtask

    task automatic reset_check(input string name);
        apply(1'b1, 6'h00, 6'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check(name, '0, '1);
    endtask

    function automatic row_t mk(logic r, logic [5:0] o, logic [5:0] f, logic z, logic m,
                                logic [3:0] st, logic [4:0] strb, logic [3:0] cm,
                                logic iord, logic rdst, logic m2r, logic [1:0] pcsrc);
        row_t x;
        x.rst = r; x.op = o; x.fn = f; x.z = z; x.mr = m; x.st = st; x.strb = strb; x.cm = cm;
        x.iord = iord; x.rdst = rdst; x.m2r = m2r; x.pcsrc = pcsrc; x.cause = 2'b00;
        return x;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn, output bit ok);
        ok = 1'b1;
        if (fn == 6'h20) return 3'b010;
        if (fn == 6'h22) return 3'b110;
        if (fn == 6'h24) return 3'b000;
        if (fn == 6'h25) return 3'b001;
        if (fn == 6'h2A) return 3'b111;
        ok = 1'b0;
        return 3'b000;
    endfunction

    // Expected outputs per visible phase; selects outside the phases that define them are don't-care
    task automatic ref_out(input int st, input logic [5:0] fn, input logic z, input logic mr,
                           input logic [1:0] cause, output ov_t e, output ov_t c);
        bit ok;
        e = '0; c = '0;
        c.pcw = 1; c.mrd = 1; c.mwr = 1; c.irw = 1; c.rw = 1; c.st = '1; c.cause = '1;
        e.st = 4'(st); e.cause = cause;
        case (st)
            0: begin
                e.mrd = 1; e.srcb = 2'b01; e.alu = 3'b010; e.irw = mr; e.pcw = mr;
                c.iord = 1; c.srca = 1; c.srcb = '1; c.alu = '1; c.pcsrc = '1;
            end
            1: begin e.srcb = 2'b11; e.alu = 3'b010; c.srca = 1; c.srcb = '1; c.alu = '1; end
            2: begin
                e.srca = 1; e.alu = alu_of(fn, ok);
                c.srca = 1; c.srcb = '1; c.alu = ok ? 3'b111 : 3'b000;
            end
            3, 4: begin e.srca = 1; e.srcb = 2'b10; e.alu = 3'b010; c.srca = 1; c.srcb = '1; c.alu = '1; end
            5: begin e.mrd = 1; e.iord = 1; c.iord = 1; end
            6: begin e.mwr = 1; e.iord = 1; c.iord = 1; end
            7: begin e.rw = 1; e.rdst = 1; c.rdst = 1; c.m2r = 1; end
            8: begin e.rw = 1; c.rdst = 1; c.m2r = 1; end
            9: begin e.rw = 1; e.m2r = 1; c.rdst = 1; c.m2r = 1; end
            10: begin
                e.srca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcw = z;
                c.srca = 1; c.srcb = '1; c.alu = '1; c.pcsrc = '1;
            end
            11: begin e.pcsrc = 2'b10; e.pcw = 1; c.pcsrc = '1; end
            default: ;
        endcase
    endtask

    task automatic push(input int st, input logic mr, input logic [1:0] cause);
        pe_t p;
        p.st = st; p.mr = mr; p.cause = cause;
        plan.push_back(p);
    endtask

    task automatic add_trap(input logic [1:0] cause);
        repeat (3) push(12, 1'($urandom_range(0, 1)), cause);
        trapped = 1;
    endtask

    // A memory phase waits s cycles; TO consecutive waits end in a timeout trap
    task automatic mem_phase(input int st, input int s, output bit done);
        for (int i = 0; i < s && i < int'(TO); i++) push(st, 1'b0, 2'b00);
        if (s >= int'(TO)) begin
            add_trap(2'b10);
            done = 0;
        end else begin
            push(st, 1'b1, 2'b00);
            done = 1;
        end
    endtask

    function automatic int pick_stall();
        if ($urandom_range(0, 9) < 8) return $urandom_range(0, 2);
        return $urandom_range(TO - 2, TO + 1);
    endfunction

    function automatic bit legal_op(logic [5:0] o);
        return o == R_OP || o == ADDI || o == LW || o == SW || o == BEQ || o == J;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ov_t e, c;
        logic [5:0] fr[5];
        Reset = 1'b1; op = '0; func = '0; Zero = 1'b0; mem_ready = 1'b0;
        fr[0] = 6'h20; fr[1] = 6'h22; fr[2] = 6'h24; fr[3] = 6'h25; fr[4] = 6'h2A;

        // ---------------- directed vector table ----------------
        tbl.push_back(mk(1, R_OP, F_ADD, 0, 1, 0, 5'b00000, 4'b1111, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, R_OP, F_ADD, 1, 0, 0, 5'b00000, 4'b1111, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, R_OP, F_ADD, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, R_OP, F_ADD, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, R_OP, F_ADD, 0, 1, 2, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, R_OP, F_ADD, 0, 1, 7, 5'b00001, 4'b0110, 0, 1, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 1, 4, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 0, 5, 5'b01000, 4'b1000, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 0, 5, 5'b01000, 4'b1000, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 0, 5, 5'b01000, 4'b1000, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 1, 5, 5'b01000, 4'b1000, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, LW, 6'h00, 0, 1, 9, 5'b00001, 4'b0110, 0, 0, 1, 2'b00));
        tbl.push_back(mk(0, BEQ, 6'h00, 1, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, BEQ, 6'h00, 1, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, BEQ, 6'h00, 1, 1, 10, 5'b10000, 4'b0001, 0, 0, 0, 2'b01));
        tbl.push_back(mk(0, BEQ, 6'h00, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, BEQ, 6'h00, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, BEQ, 6'h00, 0, 1, 10, 5'b00000, 4'b0001, 0, 0, 0, 2'b01));
        tbl.push_back(mk(0, SW, 6'h00, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, SW, 6'h00, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, SW, 6'h00, 0, 1, 4, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, SW, 6'h00, 0, 1, 6, 5'b00100, 4'b1000, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, J, 6'h00, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, J, 6'h00, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, J, 6'h00, 0, 1, 11, 5'b10000, 4'b0001, 0, 0, 0, 2'b10));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 1, 3, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 1, 8, 5'b00001, 4'b0110, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 0, 0, 5'b01000, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 1, 0, 5'b11010, 4'b1001, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, ADDI, 6'h00, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 0, 2'b00));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr);
            e = '0; c = '0;
            e.st = tbl[i].st; e.cause = tbl[i].cause;
            {e.pcw, e.mrd, e.mwr, e.irw, e.rw} = tbl[i].strb;
            e.iord = tbl[i].iord; e.rdst = tbl[i].rdst; e.m2r = tbl[i].m2r; e.pcsrc = tbl[i].pcsrc;
            c.st = '1; c.cause = '1; c.pcw = 1; c.mrd = 1; c.mwr = 1; c.irw = 1; c.rw = 1;
            c.iord = tbl[i].cm[3]; c.rdst = tbl[i].cm[2]; c.m2r = tbl[i].cm[1]; c.pcsrc = {2{tbl[i].cm[0]}};
            if (tbl[i].rst) c = '1;
            check($sformatf("tbl%0d", i), e, c);
        end

        // ---------------- illegal opcode trap, then reset recovery ----------------
        reset_check("ill_rst");
        apply(0, 6'h3F, 6'h00, 0, 1);
        ref_out(0, 6'h00, 0, 1, 2'b00, e, c); check("ill_fetch", e, c);
        apply(0, 6'h3F, 6'h00, 0, 1);
        ref_out(1, 6'h00, 0, 1, 2'b00, e, c); check("ill_decode", e, c);
        for (int i = 0; i < 20; i++) begin
            apply(0, 6'h3F, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ref_out(12, func, Zero, mem_ready, 2'b01, e, c);
            check($sformatf("ill_trap%0d", i), e, c);
        end
        reset_check("ill_exit_rst");
        apply(0, R_OP, F_ADD, 0, 1);
        ref_out(0, func, 0, 1, 2'b00, e, c); check("ill_exit_fetch", e, c);

        // ---------------- memory timeout in FETCH ----------------
        reset_check("to_rst");
        for (int i = 0; i < int'(TO); i++) begin
            apply(0, R_OP, F_ADD, 0, 0);
            ref_out(0, func, 0, 0, 2'b00, e, c); check($sformatf("to_wait%0d", i), e, c);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, R_OP, F_ADD, 0, 1'($urandom_range(0, 1)));
            ref_out(12, func, 0, mem_ready, 2'b10, e, c); check($sformatf("to_trap%0d", i), e, c);
        end

        // reset mid-wait clears the wait count; ready on the last allowed cycle wins
        reset_check("mid_rst0");
        repeat (8) apply(0, R_OP, F_ADD, 0, 0);
        reset_check("mid_wait_rst");
        for (int i = 0; i < int'(TO) - 1; i++) begin
            apply(0, R_OP, F_ADD, 0, 0);
            ref_out(0, func, 0, 0, 2'b00, e, c); check($sformatf("race_wait%0d", i), e, c);
        end
        apply(0, R_OP, F_ADD, 0, 1);
        ref_out(0, func, 0, 1, 2'b00, e, c); check("race_ready", e, c);
        apply(0, R_OP, F_ADD, 0, 1);
        ref_out(1, func, 0, 1, 2'b00, e, c); check("race_decode", e, c);

`ifdef MC_PERF_CNT_EN
        // ---------------- performance counters: j, add, sw ----------------
        reset_check("perf_rst");
        repeat (3) apply(0, J, 6'h00, 0, 1);
        repeat (4) apply(0, R_OP, F_ADD, 0, 1);
        repeat (4) apply(0, SW, 6'h00, 0, 1);
        apply(0, R_OP, F_ADD, 0, 0);
        n_checks++;
        if (cycle_cnt !== 32'd11) begin
            n_fail++;
            $display("FAIL perf_cycle: got %0d expected 11", cycle_cnt);
        end
        n_checks++;
        if (retire_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_retire: got %0d expected 3", retire_cnt);
        end
`endif

        // ---------------- randomized instruction stream ----------------
        reset_check("rnd_rst");
        for (int n = 0; n < 200; n++) begin
            int  k;
            bit  done;
            logic [5:0] o, f;
            plan.delete();
            trapped = 0;
            k = $urandom_range(0, 11);
            f = 6'($urandom_range(0, 63));
            case (k)
                0, 1, 2, 3, 4: begin o = R_OP; f = fr[k]; end
                5: o = ADDI;
                6: o = LW;
                7: o = SW;
                8: o = BEQ;
                9: o = J;
                10: begin
                    o = 6'h3F;
                    for (int t = 0; t < 100; t++) begin
                        logic [5:0] cand;
                        cand = 6'($urandom_range(0, 63));
                        if (!legal_op(cand)) begin o = cand; break; end
                    end
                end
                default: begin
                    bit ok;
                    o = R_OP;
                    f = 6'h3F;
                    for (int t = 0; t < 100; t++) begin
                        logic [5:0] cand;
                        cand = 6'($urandom_range(0, 63));
                        void'(alu_of(cand, ok));
                        if (!ok) begin f = cand; break; end
                    end
                end
            endcase

            mem_phase(0, pick_stall(), done);
            if (done) begin
                push(1, 1'($urandom_range(0, 1)), 2'b00);
                if (!legal_op(o)) add_trap(2'b01);
                else if (o == R_OP) begin
                    push(2, 1'($urandom_range(0, 1)), 2'b00);
                    if (k == 11) add_trap(2'b01);
                    else push(7, 1'($urandom_range(0, 1)), 2'b00);
                end else if (o == ADDI) begin
                    push(3, 1'($urandom_range(0, 1)), 2'b00);
                    push(8, 1'($urandom_range(0, 1)), 2'b00);
                end else if (o == LW || o == SW) begin
                    push(4, 1'($urandom_range(0, 1)), 2'b00);
                    mem_phase(o == LW ? 5 : 6, pick_stall(), done);
                    if (done && o == LW) push(9, 1'($urandom_range(0, 1)), 2'b00);
                end else if (o == BEQ) push(10, 1'($urandom_range(0, 1)), 2'b00);
                else push(11, 1'($urandom_range(0, 1)), 2'b00);
            end

            foreach (plan[j]) begin
                apply(0, o, f, 1'($urandom_range(0, 1)), plan[j].mr);
                ref_out(plan[j].st, f, Zero, plan[j].mr, plan[j].cause, e, c);
                check($sformatf("rnd%0d_op%h_st%0d", n, o, plan[j].st), e, c);
            end
            if (trapped) reset_check($sformatf("rnd%0d_rst", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
